// File: rtl/rnn_ctrl_pkg.sv
// Shared definitions for the RNN training-datapath controllers:
// the sequencer state encoding and a constant-evaluable clog2.
package rnn_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Ceiling log2, at least 1 so a 2-entry RAM still gets a 1-bit address.
    function automatic int clog2(input int value);
        int result;
        int rest;
        result = 0;
        rest   = value - 1;
        while (rest > 0) begin
            result = result + 1;
            rest   = rest >> 1;
        end
        if (result < 1) begin
            result = 1;
        end else begin
            result = result;
        end
        return result;
    endfunction

endpackage

// File: rtl/weight_ram_sequencer_if.sv
// Handshake bundle between the weight RAM sequencer and its neighbours:
// sweep control from the scheduler, the row stream to the matrix-vector
// unit and the write-back channel from the weight-update unit.
interface weight_ram_sequencer_if #(
    parameter int NROW     = 16,
    parameter int NCOL     = 16,
    parameter int BITWIDTH = 18,
    parameter int ADDR_W   = rnn_ctrl_pkg::clog2(NCOL)
);
    logic                     sweep_start;
    logic [ADDR_W-1:0]        sweep_lo;
    logic [ADDR_W-1:0]        sweep_hi;
    logic                     sweep_stall;
    logic                     sweep_busy;
    logic                     sweep_done;
    logic                     row_valid;
    logic [ADDR_W-1:0]        row_index;
    logic [NROW*BITWIDTH-1:0] row_data;
    logic                     upd_valid;
    logic                     upd_ready;
    logic [ADDR_W-1:0]        upd_addr;
    logic [NROW*BITWIDTH-1:0] upd_row;
    logic                     cfg_err;

    modport master (
        output sweep_start, sweep_lo, sweep_hi, sweep_stall,
        output upd_valid, upd_addr, upd_row,
        input  sweep_busy, sweep_done, row_valid, row_index, row_data,
        input  upd_ready, cfg_err
    );

    modport slave (
        input  sweep_start, sweep_lo, sweep_hi, sweep_stall,
        input  upd_valid, upd_addr, upd_row,
        output sweep_busy, sweep_done, row_valid, row_index, row_data,
        output upd_ready, cfg_err
    );
endinterface

// File: rtl/wrap_counter.sv
// Row pointer: loadable, advances on enable and wraps from LAST back to 0,
// so non-power-of-two RAM depths wrap correctly.
module wrap_counter #(
    parameter int ADDR_W = 4,
    parameter int LAST   = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              en,
    output logic [ADDR_W-1:0] count
);
    localparam logic [ADDR_W-1:0] LAST_C = ADDR_W'(LAST);
    localparam logic [ADDR_W-1:0] ONE_C  = ADDR_W'(1);

    logic [ADDR_W-1:0] count_r;

    // Load has priority over advance; advance wraps at LAST.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= load_val;
        end else if (en) begin
            count_r <= (count_r == LAST_C) ? '0 : count_r + ONE_C;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
endmodule

// File: rtl/weight_ram_sequencer.sv
// Owns both ports of one weight RAM: streams a contiguous (possibly
// wrapping) range of rows to the consumer during a sweep, and accepts
// row write-backs while idle. RAM reads on negedge; this block re-registers
// the read data on posedge so row_data lines up with row_valid.
module weight_ram_sequencer
    import rnn_ctrl_pkg::*;
#(
    parameter int NROW     = 16,
    parameter int NCOL     = 16,
    parameter int BITWIDTH = 18,
    parameter int ADDR_W   = clog2(NCOL)
) (
    input  logic                     clk,
    input  logic                     reset,
    weight_ram_sequencer_if.slave    bus,
    output logic [ADDR_W-1:0]        ram_addr_in,
    output logic [ADDR_W-1:0]        ram_addr_out,
    output logic                     ram_write_en,
    output logic [NROW*BITWIDTH-1:0] ram_row_in,
    input  logic [NROW*BITWIDTH-1:0] ram_row_out
);
    localparam int              ROW_W  = NROW * BITWIDTH;
    localparam logic [ADDR_W:0] NCOL_W = (ADDR_W + 1)'(NCOL);
    localparam logic [ADDR_W:0] ONE_W  = (ADDR_W + 1)'(1);

    state_t            state_r;
    logic [ADDR_W:0]   remain_r;
    logic              busy_r;
    logic              done_r;
    logic              row_valid_r;
    logic [ADDR_W-1:0] row_index_r;
    logic [ROW_W-1:0]  row_data_r;
    logic              cfg_err_r;
    logic              wr_en_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [ROW_W-1:0]  wr_row_r;

    logic [ADDR_W-1:0] ptr_s;
    logic [ADDR_W:0]   lo_ext_s;
    logic [ADDR_W:0]   hi_ext_s;
    logic [ADDR_W:0]   count_s;
    logic              start_ok_s;
    logic              start_bad_s;
    logic              issue_s;
    logic              upd_ready_s;
    logic              upd_ok_s;
    logic              upd_bad_s;

    // Decode start/write acceptance, issue strobe and sweep length.
    always_comb begin
        lo_ext_s    = {1'b0, bus.sweep_lo};
        hi_ext_s    = {1'b0, bus.sweep_hi};
        start_ok_s  = 1'b0;
        start_bad_s = 1'b0;
        if (state_r == ST_IDLE && bus.sweep_start) begin
            if (lo_ext_s < NCOL_W && hi_ext_s < NCOL_W) begin
                start_ok_s = 1'b1;
            end else begin
                start_bad_s = 1'b1;
            end
        end else begin
            start_ok_s  = 1'b0;
            start_bad_s = 1'b0;
        end
        // Row count; the wrapped form covers lo > hi.
        if (lo_ext_s <= hi_ext_s) begin
            count_s = hi_ext_s - lo_ext_s + ONE_W;
        end else begin
            count_s = NCOL_W - lo_ext_s + hi_ext_s + ONE_W;
        end
        issue_s     = (state_r == ST_SWEEP) && !bus.sweep_stall;
        // A same-cycle start outranks a write-back.
        upd_ready_s = (state_r == ST_IDLE) && !bus.sweep_start && !reset;
        upd_ok_s    = bus.upd_valid && upd_ready_s && ({1'b0, bus.upd_addr} < NCOL_W);
        upd_bad_s   = bus.upd_valid && upd_ready_s && !({1'b0, bus.upd_addr} < NCOL_W);
    end

    wrap_counter #(
        .ADDR_W (ADDR_W),
        .LAST   (NCOL - 1)
    ) u_ptr (
        .clk      (clk),
        .reset    (reset),
        .load     (start_ok_s),
        .load_val (bus.sweep_lo),
        .en       (issue_s),
        .count    (ptr_s)
    );

    // Sweep FSM: the remaining-row count, not ptr==hi, ends the sweep so
    // both single-row and full-wrap ranges terminate correctly.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            remain_r <= '0;
            busy_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_ok_s) begin
                        state_r  <= ST_SWEEP;
                        remain_r <= count_s;
                        busy_r   <= 1'b1;
                    end else begin
                        state_r  <= ST_IDLE;
                        busy_r   <= 1'b0;
                    end
                end
                ST_SWEEP: begin
                    if (issue_s) begin
                        remain_r <= remain_r - ONE_W;
                        if (remain_r == ONE_W) begin
                            state_r <= ST_FLUSH;
                        end else begin
                            state_r <= ST_SWEEP;
                        end
                    end else begin
                        remain_r <= remain_r;
                    end
                end
                ST_FLUSH: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Read-return, write-back and error registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_valid_r <= 1'b0;
            row_index_r <= '0;
            row_data_r  <= '0;
            done_r      <= 1'b0;
            cfg_err_r   <= 1'b0;
            wr_en_r     <= 1'b0;
            wr_addr_r   <= '0;
            wr_row_r    <= '0;
        end else begin
            row_valid_r <= issue_s;
            done_r      <= issue_s && (remain_r == ONE_W);
            cfg_err_r   <= start_bad_s || upd_bad_s;
            wr_en_r     <= upd_ok_s;
            if (issue_s) begin
                row_index_r <= ptr_s;
                row_data_r  <= ram_row_out;
            end else begin
                row_index_r <= row_index_r;
                row_data_r  <= row_data_r;
            end
            if (upd_ok_s) begin
                wr_addr_r <= bus.upd_addr;
                wr_row_r  <= bus.upd_row;
            end else begin
                wr_addr_r <= wr_addr_r;
                wr_row_r  <= wr_row_r;
            end
        end
    end

    assign bus.sweep_busy = busy_r;
    assign bus.sweep_done = done_r;
    assign bus.row_valid  = row_valid_r;
    assign bus.row_index  = row_index_r;
    assign bus.row_data   = row_data_r;
    assign bus.upd_ready  = upd_ready_s;
    assign bus.cfg_err    = cfg_err_r;
    assign ram_addr_out   = ptr_s;
    assign ram_addr_in    = wr_addr_r;
    assign ram_write_en   = wr_en_r;
    assign ram_row_in     = wr_row_r;
endmodule

// File: tb/tb_weight_ram_sequencer.sv
// Bench for weight_ram_sequencer: a RAM model, a reference row store and
// expectation queues filled by the stimulus tasks; a negedge monitor pops
// and compares whatever the DUT presents.
module tb_weight_ram_sequencer;
    localparam int NROW = 16;
    localparam int NCOL = 16;
    localparam int BW   = 18;
    localparam int AW   = 5;
    localparam int RW   = NROW * BW;

    typedef struct {
        logic [AW-1:0] idx;
        logic [RW-1:0] data;
        logic          last;
    } row_t;
    typedef struct {
        logic [AW-1:0] addr;
        logic [RW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] ram_addr_in;
    logic [AW-1:0] ram_addr_out;
    logic          ram_write_en;
    logic [RW-1:0] ram_row_in;
    logic [RW-1:0] ram_row_out;

    logic [RW-1:0] mem [NCOL];
    logic [RW-1:0] ref_mem [NCOL];

    row_t row_q [$];
    wr_t  wr_q [$];
    int   err_q [$];
    int   busy_q [$];

    int n_checks = 0;
    int n_fail = 0;
    int busy_run = 0;

    always #5 clk = ~clk;

    weight_ram_sequencer_if #(.NROW(NROW), .NCOL(NCOL), .BITWIDTH(BW), .ADDR_W(AW)) bus ();

    weight_ram_sequencer #(.NROW(NROW), .NCOL(NCOL), .BITWIDTH(BW), .ADDR_W(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .ram_addr_in  (ram_addr_in),
        .ram_addr_out (ram_addr_out),
        .ram_write_en (ram_write_en),
        .ram_row_in   (ram_row_in),
        .ram_row_out  (ram_row_out)
    );

    // Weight RAM: negedge write, negedge registered read (old data on collision).
    always @(negedge clk) begin
        if (ram_write_en && ram_addr_in < AW'(NCOL)) mem[ram_addr_in] <= ram_row_in;
        if (ram_addr_out < AW'(NCOL)) ram_row_out <= mem[ram_addr_out];
        else ram_row_out <= '0;
    end

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [RW-1:0] lane_fill(input int v);
        logic [RW-1:0] d;
        for (int l = 0; l < NROW; l++) d[l*BW +: BW] = BW'(v);
        return d;
    endfunction

    function automatic logic [RW-1:0] rand_row();
        logic [RW-1:0] d;
        for (int l = 0; l < NROW; l++) d[l*BW +: BW] = BW'($urandom);
        return d;
    endfunction

    // Monitor: pop and compare whatever the DUT presents this cycle.
    always @(negedge clk) begin
        row_t e;
        wr_t  w;
        int   b;
        if (bus.row_valid) begin
            check("row_expected", RW'(row_q.size() != 0), RW'(1));
            if (row_q.size() != 0) begin
                e = row_q.pop_front();
                check("row_index", RW'(bus.row_index), RW'(e.idx));
                check("row_data", bus.row_data, e.data);
                check("sweep_done", RW'(bus.sweep_done), RW'(e.last));
            end
        end else if (bus.sweep_done) begin
            check("done_with_valid", RW'(bus.row_valid), RW'(1));
        end
        if (ram_write_en) begin
            check("write_expected", RW'(wr_q.size() != 0), RW'(1));
            if (wr_q.size() != 0) begin
                w = wr_q.pop_front();
                check("ram_addr_in", RW'(ram_addr_in), RW'(w.addr));
                check("ram_row_in", ram_row_in, w.data);
            end
        end
        if (bus.cfg_err) begin
            check("cfg_err_expected", RW'(err_q.size() != 0), RW'(1));
            if (err_q.size() != 0) b = err_q.pop_front();
        end
        if (bus.sweep_busy) begin
            busy_run++;
        end else if (busy_run > 0) begin
            check("busy_expected", RW'(busy_q.size() != 0), RW'(1));
            if (busy_q.size() != 0) begin
                b = busy_q.pop_front();
                check("busy_cycles", RW'(busy_run), RW'(b));
            end
            busy_run = 0;
        end
    end

    task automatic check_zero_outputs(input string tag);
        check({tag, "_row_valid"}, RW'(bus.row_valid), RW'(0));
        check({tag, "_sweep_done"}, RW'(bus.sweep_done), RW'(0));
        check({tag, "_sweep_busy"}, RW'(bus.sweep_busy), RW'(0));
        check({tag, "_cfg_err"}, RW'(bus.cfg_err), RW'(0));
        check({tag, "_ram_write_en"}, RW'(ram_write_en), RW'(0));
        check({tag, "_row_index"}, RW'(bus.row_index), RW'(0));
        check({tag, "_row_data"}, bus.row_data, RW'(0));
        check({tag, "_ram_addr_in"}, RW'(ram_addr_in), RW'(0));
        check({tag, "_ram_addr_out"}, RW'(ram_addr_out), RW'(0));
        check({tag, "_ram_row_in"}, ram_row_in, RW'(0));
    endtask

    // Write-back: holds valid until the DUT takes it, then records the expectation.
    task automatic do_write(input int addr, input logic [RW-1:0] data);
        logic fired;
        bus.upd_valid = 1'b1;
        bus.upd_addr  = AW'(addr);
        bus.upd_row   = data;
        fired = 1'b0;
        for (int i = 0; i < 100 && !fired; i++) begin
            @(negedge clk);
            fired = bus.upd_ready;
            @(posedge clk);
            #1;
        end
        bus.upd_valid = 1'b0;
        check("write_accepted", RW'(fired), RW'(1));
        if (fired) begin
            if (addr < NCOL) begin
                wr_q.push_back('{addr: AW'(addr), data: data});
                ref_mem[addr] = data;
            end else begin
                err_q.push_back(1);
            end
        end
    endtask

    // Sweep: expected rows come from the reference store; stall either a
    // fixed burst after a given issue count or randomly.
    task automatic run_sweep(input int lo, input int hi, input int stall_after,
                             input int stall_len, input int stall_pct);
        int   n, issued, stalls, left;
        logic ok, stall;
        ok = (lo < NCOL) && (hi < NCOL);
        bus.sweep_lo    = AW'(lo);
        bus.sweep_hi    = AW'(hi);
        bus.sweep_start = 1'b1;
        n = 0;
        if (ok) begin
            n = (lo <= hi) ? hi - lo + 1 : NCOL - lo + hi + 1;
            for (int k = 0; k < n; k++)
                row_q.push_back('{idx: AW'((lo + k) % NCOL), data: ref_mem[(lo + k) % NCOL],
                                  last: (k == n - 1)});
        end else begin
            err_q.push_back(1);
        end
        @(posedge clk);
        #1;
        bus.sweep_start = 1'b0;
        if (!ok) begin
            @(negedge clk);
            check("rejected_no_busy", RW'(bus.sweep_busy), RW'(0));
            @(posedge clk);
            #1;
        end else begin
            issued = 0;
            stalls = 0;
            left   = stall_len;
            while (issued < n) begin
                if (issued == stall_after && left > 0) begin
                    stall = 1'b1;
                    left--;
                end else if (stall_pct > 0 && $urandom_range(99) < stall_pct) begin
                    stall = 1'b1;
                end else begin
                    stall = 1'b0;
                end
                bus.sweep_stall = stall;
                @(posedge clk);
                #1;
                if (stall) stalls++;
                else issued++;
            end
            bus.sweep_stall = 1'b0;
            busy_q.push_back(n + 1 + stalls);
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (!bus.sweep_busy) break;
            end
            check("sweep_finished", RW'(bus.sweep_busy), RW'(0));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.sweep_start = 1'b0;
        bus.sweep_lo    = '0;
        bus.sweep_hi    = '0;
        bus.sweep_stall = 1'b0;
        bus.upd_valid   = 1'b0;
        bus.upd_addr    = '0;
        bus.upd_row     = '0;
        for (int i = 0; i < NCOL; i++) ref_mem[i] = '0;

        // Power-on reset: ready held low and all outputs cleared.
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_upd_ready", RW'(bus.upd_ready), RW'(0));
        check_zero_outputs("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Fill rows with their own index, then a full sweep.
        for (int i = 0; i < NCOL; i++) do_write(i, lane_fill(i));
        run_sweep(0, 15, -1, 0, 0);

        // Wrapping range and single row.
        run_sweep(14, 1, -1, 0, 0);
        run_sweep(5, 5, -1, 0, 0);

        // Three stall cycles after the second issue.
        run_sweep(0, 15, 2, 3, 0);

        // Start and write-back in the same cycle: sweep wins, write after.
        fork
            run_sweep(3, 6, -1, 0, 0);
            do_write(4, lane_fill(16'h0aa4));
            begin
                @(negedge clk);
                check("ready_low_on_start", RW'(bus.upd_ready), RW'(0));
            end
        join
        // Write to row 3 one cycle before a start: sweep sees new data.
        do_write(3, lane_fill(16'h0bb3));
        run_sweep(2, 4, -1, 0, 0);

        // Out-of-range write and start requests.
        do_write(16, lane_fill(7));
        run_sweep(0, 16, -1, 0, 0);
        run_sweep(17, 2, -1, 0, 0);
        run_sweep(1, 2, -1, 0, 0);

        // Reset on the fourth issue cycle of a sweep.
        bus.sweep_lo    = AW'(0);
        bus.sweep_hi    = AW'(15);
        bus.sweep_start = 1'b1;
        for (int k = 0; k < 3; k++)
            row_q.push_back('{idx: AW'(k), data: ref_mem[k], last: 1'b0});
        busy_q.push_back(4);
        @(posedge clk);
        #1;
        bus.sweep_start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_zero_outputs("midreset");
        @(posedge clk);
        #1;
        run_sweep(0, 15, -1, 0, 0);

        // Randomized writes and sweeps against the reference store.
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(1) == 0) begin
                do_write($urandom_range(NCOL + 2), rand_row());
            end else begin
                run_sweep($urandom_range(NCOL + 1), $urandom_range(NCOL + 1), -1, 0,
                          $urandom_range(40));
            end
        end

        repeat (5) @(posedge clk);
        #1;
        check("rows_drained", RW'(row_q.size()), RW'(0));
        check("writes_drained", RW'(wr_q.size()), RW'(0));
        check("errs_drained", RW'(err_q.size()), RW'(0));
        check("busy_drained", RW'(busy_q.size()), RW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/weight_ram_sequencer.md
# weight_ram_sequencer

Controller that owns both ports of one weight RAM (`NCOL` rows of `NROW*BITWIDTH` bits, negedge write/registered read) in the RNN training datapath. It streams a contiguous, optionally wrapping, range of weight rows to the matrix-vector unit as a sweep. Between sweeps, it accepts row write-backs from the weight-update unit. It registers the RAM read data on posedge so the consumer sees `row_data` aligned with `row_valid`.

## Interface
- `NROW`, 16, weights per RAM row
- `NCOL`, 16, number of RAM rows (any value ≥2; not required to be a power of two)
- `BITWIDTH`, 18, bits per weight
- `ADDR_W`, clog2(`NCOL`), address width
- `clk` in 1: all logic on rising edge; RAM side is negedge.
- `reset` in 1: reset, synchronous, active-high.
- `sweep_start` in 1: start request, sampled only in IDLE.
- `sweep_lo`, `sweep_hi` in `ADDR_W`: inclusive first and last row, latched on start.
- `sweep_stall` in 1: when high, no new read is issued this cycle.
- `sweep_busy` out 1: high from the first issue cycle through the last `row_valid`.
- `sweep_done` out 1: one-cycle pulse, coincident with the last `row_valid`.
- `row_valid` out 1: `row_data`/`row_index` valid this cycle.
- `row_index` out `ADDR_W`: RAM row of `row_data`.
- `row_data` out `NROW*BITWIDTH`: registered RAM row.
- `upd_valid` in 1, `upd_ready` out 1: write-back handshake.
- `upd_addr` in `ADDR_W`, `upd_row` in `NROW*BITWIDTH`: write-back payload.
- `cfg_err` out 1: one-cycle pulse on a rejected start or write.
- `ram_addr_in`, `ram_addr_out` out `ADDR_W`; `ram_write_en` out 1; `ram_row_in` out `NROW*BITWIDTH`; `ram_row_out` in `NROW*BITWIDTH`.

## Operation
- States: IDLE, SWEEP, FLUSH.
- IDLE:
  - `upd_ready` = !`sweep_start`, so a start has priority over a write-back in the same cycle.
  - Write-back transfer (valid&ready at the edge) with `upd_addr` < `NCOL`: next cycle drive `ram_write_en`=1, `ram_addr_in`=`upd_addr`, `ram_row_in`=`upd_row` for exactly one cycle.
  - Write-back with `upd_addr` ≥ `NCOL`: still consumed, no write issued, `cfg_err` pulses.
  - Back-to-back writes are allowed, one per cycle.
- Sweep start in IDLE:
  - `sweep_lo` or `sweep_hi` ≥ `NCOL`: start rejected, `cfg_err` pulses, state stays IDLE.
  - Otherwise latch lo/hi, set the read pointer to lo, and go to SWEEP.
  - Row count N = hi−lo+1 if lo≤hi, else NCOL−lo+hi+1 (wraps NCOL−1→0). lo==hi gives N=1.
- SWEEP:
  - Each cycle with `sweep_stall`=0: issue a read by driving `ram_addr_out`=ptr, mark the issue, and advance ptr (wrapping at `NCOL`−1).
  - When stalled: ptr holds and nothing is marked.
  - After the N-th issue, go to FLUSH.
- FLUSH: lasts one cycle and returns to IDLE.
- Read data path: at each posedge following an issue cycle, `row_data`←`ram_row_out` and `row_index`←issued address, with `row_valid`=1 that cycle.
  - `sweep_stall` does not cancel a read already issued; the consumer must accept every `row_valid`.
- `sweep_start` while not in IDLE is ignored, with no error.
- `upd_ready`=0 in SWEEP and FLUSH. A pending `upd_valid` waits.
- The RAM's own reset is not driven by this block.

## Timing
- Reset values:
  - State IDLE.
  - `sweep_busy`, `sweep_done`, `row_valid`, `ram_write_en`, `cfg_err` = 0.
  - `row_index`, `row_data`, `ram_addr_in`, `ram_addr_out`, `ram_row_in` = 0.
  - `upd_ready` = 0 during the reset cycle.
- Reset mid-sweep: abort immediately. No `sweep_done`, no `row_valid` for the in-flight read, and no RAM write in the following cycle.
- Sweep start sampled at the edge ending cycle t, no stalls:
  - Issues in cycles t+1..t+N.
  - `row_valid` in t+2..t+N+1.
  - `sweep_done` in t+N+1 (FLUSH).
  - IDLE from t+N+2.
  - `sweep_busy` high t+1..t+N+1.
  - Each stall cycle extends all of the above by one.
- Write-back accepted at the edge ending t: RAM write strobed in t+1, committed at the negedge of t+1. A sweep started at the end of t+1 reads the new data.
- Throughput: one row per cycle when not stalled.

## Structure
- Shared package `rnn_ctrl_pkg`: `clog2` function and the state enum (IDLE/SWEEP/FLUSH).
- One sub-module, `wrap_counter`: `ADDR_W`-bit pointer with load, enable, and wrap at a `NCOL`−1 parameter. It is used for ptr.
- Sweep length is tracked with a separate remaining-count register, not by comparing ptr to hi, so that lo==hi and full wrap both work.

## Test plan
- Write rows 0..15 with row=i in each lane, then sweep lo=0, hi=15 → 16 consecutive `row_valid`, index/data 0..15, `sweep_done` on index 15, busy 17 cycles.
- Sweep lo=14, hi=1, NCOL=16 → indices 14,15,0,1; `sweep_done` with index 1; lo=hi=5 → single row 5 with done.
- `sweep_stall` high for 3 cycles after the 2nd issue → exactly 2 rows delivered before the gap, no duplicates or drops, done 3 cycles later.
- `upd_valid` and `sweep_start` in the same IDLE cycle → sweep wins, `upd_ready`=0, write lands after FLUSH. A write to addr 3 one cycle before a start → sweep row 3 shows the new value.
- `upd_addr`=16 or `sweep_hi`=16 → `cfg_err` pulse, no RAM write, state IDLE.
- Reset asserted on the 4th issue cycle → all outputs zero next cycle, no done; a new sweep afterward runs normally.
